alu_share_arb: RTL
==================

# alu_share_arb

Arbiter that shares the single-cycle integer ALU between `N` requesters, e.g. the execute stage and a multi-cycle address/branch helper. It accepts at most one request per cycle with a valid/ready handshake, drives the shared ALU combinationally and registers the result. It then returns the result to the winning requester through a one-entry response slot with its own valid/ready handshake.

## Interface
Parameters:
- `N`, default 2, number of requesters (2..8).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N  requester i presents an operation.
- `req_ready`  out  N  requester i's operation is accepted this cycle (one-hot or zero).
- `req_funct`  in  4*N  ALU function code; slice i is `[4i+3:4i]`.
- `req_in1`  in  32*N  operand 1; slice i is `[32i+31:32i]`.
- `req_in2`  in  32*N  operand 2; slice i is `[32i+31:32i]`.
- `resp_valid`  out  N  result pending for requester i (one-hot or zero).
- `resp_ready`  in  N  requester i consumes its result.
- `resp_data`  out  32  result; meaningful only while some `resp_valid` bit is 1.
- `alu_funct`  out  4  to shared ALU.
- `alu_in1`  out  32  to shared ALU.
- `alu_in2`  out  32  to shared ALU.
- `alu_out`  in  32  combinational ALU result.

## Operation
- ALU codes are passed through without interpretation:
  - 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 xor
  - 6 sra, 7 srl, 8 sltu, 9 slt
  - any other code gives 0 at `alu_out`
- State:
  - `pend`: 1 bit, response slot occupied.
  - `owner`: log2(N) bits.
  - `res`: 32 bits.
  - `last`: log2(N) bits, last granted index.
- FSM has two states:
  - EMPTY (`pend`=0).
  - FULL (`pend`=1).
- `slot_free` = EMPTY, or FULL with `resp_ready[owner]`=1 this cycle.
- Grant (round-robin):
  - Only when `slot_free`.
  - Winner is the first i with `req_valid[i]`=1, scanning from `(last+1) mod N` upward with wrap.
  - `req_ready[winner]`=1. All other `req_ready` bits are 0.
- The ALU inputs carry the winner's funct/in1/in2. With no grant they are driven to 0.
- On a grant edge:
  - `res` ← `alu_out`
  - `owner` ← winner
  - `last` ← winner
  - `pend` ← 1
- Response slot:
  - `resp_valid[owner]` = `pend`.
  - `resp_data` = `res`.
- FULL, `resp_ready[owner]`=1, and no grant → EMPTY.
- FULL, `resp_ready[owner]`=1, and a grant in the same cycle → stays FULL with the new result (back-to-back).
- FULL, `resp_ready[owner]`=0:
  - `req_ready` = 0.
  - `res`, `owner` and `resp_data` are held stable.
- `resp_ready[j]` for j≠owner, or while EMPTY, is ignored.
- A requester may hold `req_valid` high across cycles. Operands are sampled only on the grant cycle.
- A requester that is still waiting for its own response may be granted again in the same cycle its response is consumed.

## Timing
- Reset, asynchronous, all state is cleared:
  - `pend`=0, `owner`=0, `res`=0.
  - `last`=N-1, so index 0 has first priority.
- While `reset` is high:
  - `req_ready`=0, `resp_valid`=0, `resp_data`=0.
  - `alu_funct`=0, `alu_in1`=0, `alu_in2`=0.
- Reset mid-operation discards any pending result. It is not delivered.
- Latency: a request accepted at edge t has `resp_valid` high and `resp_data` valid from after edge t, i.e. the next cycle.
- Throughput: one operation per cycle when responses are consumed immediately.
- `req_ready` depends combinationally on `req_valid` and `resp_ready`; `resp_valid` does not.
  - Requesters must not make `req_valid` depend on `req_ready`.
  - Requesters must not make `resp_ready` depend on `req_ready`.
- Combinational path `req_*` → `alu_*` → `alu_out` → `res`: a single ALU delay within one cycle.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. The lowest valid index always wins. `last` is not implemented.
  - Undefined (default): round-robin as described above.

## Test plan
- Single requester:
  - Stimulus: req0 funct=0, in1=5, in2=3.
  - Required: `req_ready`=01 in the same cycle; next cycle `resp_valid`=01 and `resp_data`=8. After `resp_ready[0]`=1 the slot empties.
- Contention, round-robin, `resp_ready` tied high:
  - Stimulus: both held valid; req0 sub 10-4, req1 nor 0,0.
  - Required: grants alternate 0,1,0,1 starting with 0. Responses are 6 and 0xFFFFFFFF in order, one per cycle.
- Backpressure:
  - Stimulus: req1 slt in1=0xFFFFFFFF, in2=1; `resp_ready[1]` held 0 for 3 cycles while req0 is valid.
  - Required: `resp_data`=1 held stable and `req_ready`=00. In the cycle `resp_ready[1]` rises, req0 is granted, and its result appears the next cycle.
- Back-to-back, same requester:
  - Stimulus: req0 sra 0x80000000 by 4, then srl 0x80000000 by 4, with `resp_ready[0]`=1.
  - Required: 0xF8000000 then 0x08000000 on consecutive cycles.
- Reset mid-operation:
  - Stimulus: assert `reset` while FULL.
  - Required: `resp_valid` is 0 immediately. After release, both requesters valid grants index 0 first.
- With `ALU_ARB_FIXED_PRIO_EN` defined:
  - Stimulus: both requesters valid for 4 cycles.
  - Required: index 0 is granted every cycle; `req_ready[1]` is never 1.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one single-cycle ALU between N requesters.
// At most one request is accepted per cycle, chosen round-robin. The request
// drives the shared ALU combinationally. The result is registered into a
// one-entry response slot that is returned to the winning requester.
//
// Optional feature: define ALU_ARB_FIXED_PRIO_EN to select fixed priority,
// where the lowest valid index wins. No last-grant pointer is kept in that
// build.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   req_valid/req_ready [N]    request handshake (ready is one-hot or zero)
//   req_funct [4N]             per-requester ALU function code
//   req_in1, req_in2 [32N]     per-requester operands
//   resp_valid [N]             response pending for owner (one-hot or zero)
//   resp_ready [N]             response consumed (only owner's bit matters)
//   resp_data [32]             registered result
//   alu_funct/alu_in1/alu_in2  to shared ALU (zero when nothing is granted)
//   alu_out [32]               combinational ALU result
module alu_share_arb #(
    parameter int unsigned N = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [4*N-1:0]  req_funct,
    input  logic [32*N-1:0] req_in1,
    input  logic [32*N-1:0] req_in2,
    output logic [N-1:0]    resp_valid,
    input  logic [N-1:0]    resp_ready,
    output logic [31:0]     resp_data,
    output logic [3:0]      alu_funct,
    output logic [31:0]     alu_in1,
    output logic [31:0]     alu_in2,
    input  logic [31:0]     alu_out
);

    localparam int unsigned IW = $clog2(N);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state;
    logic [IW-1:0]  owner;
    logic [31:0]    res;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [IW-1:0]  last;
`endif

    logic           slot_free;
    logic           can_grant;
    logic           grant;
    logic [IW-1:0]  winner;

    // Slot can take a new result if empty or being drained this cycle.
    always_comb begin
        slot_free = (state == EMPTY) || resp_ready[owner];
        can_grant = slot_free && !reset;
    end

    // Winner selection.
    always_comb begin
        grant  = 1'b0;
        winner = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < N; i++) begin
            if (!grant && req_valid[IW'(i)]) begin
                grant  = 1'b1;
                winner = IW'(i);
            end
        end
`else
        // Scan from last+1 upward with wrap so the previous winner goes last.
        for (int unsigned k = 1; k <= N; k++) begin
            if (!grant && req_valid[IW'((32'(last) + k) % N)]) begin
                grant  = 1'b1;
                winner = IW'((32'(last) + k) % N);
            end
        end
`endif
        grant = grant && can_grant;
    end

    // Handshake and ALU drive.
    always_comb begin
        req_ready  = grant ? (N'(1) << winner) : '0;
        alu_funct  = grant ? req_funct[{winner, 2'b00} +: 4] : 4'd0;
        alu_in1    = grant ? req_in1[{winner, 5'd0} +: 32] : 32'd0;
        alu_in2    = grant ? req_in2[{winner, 5'd0} +: 32] : 32'd0;
        resp_valid = (state == FULL) ? (N'(1) << owner) : '0;
        resp_data  = res;
    end

    // Response slot FSM. A grant refills the slot, even while it drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            owner <= '0;
            res   <= 32'd0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last  <= IW'(N - 1);
`endif
        end else begin
            case (state)
                EMPTY: begin
                    if (grant) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (!grant && resp_ready[owner]) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            if (grant) begin
                res   <= alu_out;
                owner <= winner;
`ifndef ALU_ARB_FIXED_PRIO_EN
                last  <= winner;
`endif
            end
        end
    end

endmodule
